// File: rtl/pmu_frame_serializer.sv
// ---------------------------------------------------------------------------
// pmu_frame_serializer
//
// Captures one NUM_WORDS x 64-bit converted frame on LOAD and streams it out
// as bytes over a valid/ready handshake. A frame is a SYNC_BYTE header
// followed by the words in index order, each word MSB first. LOADs that
// arrive while a frame is in flight are dropped and counted in a saturating
// overrun counter. A LOAD on the final handshake of a frame is accepted and
// starts the next frame without an idle cycle.
//
// Optional feature (macro PMU_SERIALIZER_CHECKSUM_EN): appends one byte that
// is the XOR of all data bytes of the frame (sync byte excluded).
//
// Ports:
//   CLK        in   system clock, rising edge
//   RST        in   asynchronous, active-high reset
//   LOAD       in   one-cycle strobe: capture DIN and start a frame
//   DIN        in   NUM_WORDS x 64-bit frame, index 0 sent first
//   BUSY       out  frame in progress
//   DOUT       out  current stream byte
//   DVALID     out  DOUT is valid
//   DREADY     in   sink accepts DOUT this cycle
//   FRAME_DONE out  one-cycle pulse after the final handshake of a frame
//   OVR_CNT    out  saturating count of LOADs dropped while busy
// ---------------------------------------------------------------------------
module pmu_frame_serializer #(
    parameter int         NUM_WORDS = 4,
    parameter logic [7:0] SYNC_BYTE = 8'hAA,
    parameter int         OVR_W     = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             LOAD,
    input  logic [63:0]      DIN [NUM_WORDS-1:0],
    output logic             BUSY,
    output logic [7:0]       DOUT,
    output logic             DVALID,
    input  logic             DREADY,
    output logic             FRAME_DONE,
    output logic [OVR_W-1:0] OVR_CNT
);

    localparam int NUM_BYTES = 8 * NUM_WORDS;
    localparam int CNT_W     = $clog2(NUM_BYTES);
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(NUM_BYTES - 1);

`ifdef PMU_SERIALIZER_CHECKSUM_EN
    typedef enum logic [1:0] {S_IDLE, S_SYNC, S_DATA, S_CKSUM} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_SYNC, S_DATA} state_t;
`endif

    state_t           state_q;
    state_t           state_d;
    logic [63:0]      frame_q [NUM_WORDS-1:0];
    logic [CNT_W-1:0] byte_cnt_q;
    logic             done_q;
    logic [OVR_W-1:0] ovr_q;

    logic             last_xfer;   // final handshake of the frame this cycle
    logic             data_xfer;   // a data byte transfers this cycle
    logic             accept;      // LOAD captured this cycle
    logic [63:0]      cur_word;
    logic [2:0]       byte_sh;
    logic [7:0]       data_byte;

`ifdef PMU_SERIALIZER_CHECKSUM_EN
    logic [7:0]       cksum_q;
`endif

    // Byte k of the frame is word[k/8], MSB first.
    assign cur_word  = frame_q[byte_cnt_q[CNT_W-1:3]];
    assign byte_sh   = 3'd7 - byte_cnt_q[2:0];
    assign data_byte = cur_word[{byte_sh, 3'b000} +: 8];

    assign BUSY       = (state_q != S_IDLE);
    assign FRAME_DONE = done_q;
    assign OVR_CNT    = ovr_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // DOUT/DVALID are decoded from state and counter only, so they hold
    // stable for as long as the sink stalls.
    always_comb begin
        state_d   = state_q;
        last_xfer = 1'b0;
        data_xfer = 1'b0;
        DVALID    = 1'b0;
        DOUT      = 8'h00;
        case (state_q)
            S_IDLE: begin
                if (LOAD) state_d = S_SYNC;
            end
            S_SYNC: begin
                DVALID = 1'b1;
                DOUT   = SYNC_BYTE;
                if (DREADY) state_d = S_DATA;
            end
            S_DATA: begin
                DVALID    = 1'b1;
                DOUT      = data_byte;
                data_xfer = DREADY;
                if (DREADY && (byte_cnt_q == LAST_BYTE)) begin
`ifdef PMU_SERIALIZER_CHECKSUM_EN
                    state_d = S_CKSUM;
`else
                    last_xfer = 1'b1;
                    state_d   = LOAD ? S_SYNC : S_IDLE;
`endif
                end
            end
`ifdef PMU_SERIALIZER_CHECKSUM_EN
            S_CKSUM: begin
                DVALID = 1'b1;
                DOUT   = cksum_q;
                if (DREADY) begin
                    last_xfer = 1'b1;
                    state_d   = LOAD ? S_SYNC : S_IDLE;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
        accept = LOAD && ((state_q == S_IDLE) || last_xfer);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            frame_q    <= '{default: '0};
            byte_cnt_q <= '0;
            done_q     <= 1'b0;
            ovr_q      <= '0;
        end else begin
            done_q <= last_xfer;
            if (accept) frame_q <= DIN;
            if (data_xfer) begin
                byte_cnt_q <= (byte_cnt_q == LAST_BYTE) ? '0 : byte_cnt_q + 1'b1;
            end
            if (LOAD && !accept && (ovr_q != '1)) ovr_q <= ovr_q + 1'b1;
        end
    end

`ifdef PMU_SERIALIZER_CHECKSUM_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cksum_q <= 8'h00;
        end else if (accept) begin
            cksum_q <= 8'h00;
        end else if (data_xfer) begin
            cksum_q <= cksum_q ^ data_byte;
        end
    end
`endif

endmodule

// File: tb/tb_pmu_frame_serializer.sv
// ---------------------------------------------------------------------------
// Directed testbench for pmu_frame_serializer (default parameters).
// Inputs change and outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_pmu_frame_serializer;

`ifdef PMU_SERIALIZER_CHECKSUM_EN
    localparam int FLEN = 34;
`else
    localparam int FLEN = 33;
`endif

    logic        CLK = 1'b0;
    logic        RST;
    logic        LOAD;
    logic [63:0] DIN [3:0];
    logic        BUSY;
    logic [7:0]  DOUT;
    logic        DVALID;
    logic        DREADY;
    logic        FRAME_DONE;
    logic [7:0]  OVR_CNT;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0] exp_s [0:33];

    pmu_frame_serializer dut (
        .CLK        (CLK),
        .RST        (RST),
        .LOAD       (LOAD),
        .DIN        (DIN),
        .BUSY       (BUSY),
        .DOUT       (DOUT),
        .DVALID     (DVALID),
        .DREADY     (DREADY),
        .FRAME_DONE (FRAME_DONE),
        .OVR_CNT    (OVR_CNT)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge CLK);
    endtask

    task automatic set_din_basic();
        DIN[0] = 64'h0102030405060708;
        DIN[1] = 64'h1112131415161718;
        DIN[2] = 64'h2122232425262728;
        DIN[3] = 64'h3132333435363738;
    endtask

    task automatic set_din_all(input logic [63:0] v);
        for (int i = 0; i < 4; i++) DIN[i] = v;
    endtask

    // Basic pattern: word w byte j (MSB first) is {w, j+1}; checksum 00.
    task automatic set_exp_basic();
        exp_s[0] = 8'hAA;
        for (int k = 0; k < 32; k++) exp_s[1+k] = {4'(k / 8), 4'((k % 8) + 1)};
        exp_s[33] = 8'h00;
    endtask

    // 32 x FF; XOR of an even count of FF is 00.
    task automatic set_exp_ff();
        exp_s[0] = 8'hAA;
        for (int k = 1; k <= 32; k++) exp_s[k] = 8'hFF;
        exp_s[33] = 8'h00;
    endtask

    task automatic start_frame();
        LOAD = 1'b1;
        tick();
        LOAD = 1'b0;
        chk("latency_dvalid", DVALID, 1);
        chk("latency_busy", BUSY, 1);
    endtask

    // Entered with the sync byte presented; walks the whole frame.
    //   bp  : DREADY follows 1,0,0,1 repeating
    //   ovr : three LOAD pulses with other DIN mid-frame
    //   b2b : LOAD with all-FF DIN on the final handshake
    task automatic stream(input bit bp, input bit ovr, input bit b2b);
        int         idx = 0;
        int         cyc = 0;
        bit         rdy;
        logic [3:0] pat = 4'b1001;
        while (idx < FLEN && cyc < 400) begin
            rdy    = bp ? pat[cyc % 4] : 1'b1;
            DREADY = rdy;
            LOAD   = 1'b0;
            if (ovr && (cyc == 3 || cyc == 5 || cyc == 7)) begin
                LOAD = 1'b1;
                set_din_all(64'hDEADBEEF0BADF00D);
            end
            if (b2b && rdy && idx == FLEN - 1) begin
                LOAD = 1'b1;
                set_din_all(64'hFFFFFFFFFFFFFFFF);
            end
            chk($sformatf("dvalid_b%0d", idx), DVALID, 1);
            chk($sformatf("dout_b%0d", idx), DOUT, exp_s[idx]);
            chk($sformatf("busy_b%0d", idx), BUSY, 1);
            if (cyc > 0) chk($sformatf("frame_done_b%0d", idx), FRAME_DONE, 0);
            tick();
            if (rdy) idx++;
            cyc++;
        end
        LOAD   = 1'b0;
        DREADY = 1'b1;
        if (idx < FLEN) chk("stream_timeout", idx, FLEN);
        chk("frame_done_pulse", FRAME_DONE, 1);
        if (b2b) begin
            chk("b2b_dvalid", DVALID, 1);
            chk("b2b_busy", BUSY, 1);
            chk("b2b_sync", DOUT, 8'hAA);
        end else begin
            chk("end_dvalid", DVALID, 0);
            chk("end_busy", BUSY, 0);
        end
    endtask

    initial begin
        RST    = 1'b1;
        LOAD   = 1'b0;
        DREADY = 1'b0;
        set_din_all(64'h0);
        tick();
        tick();
        chk("rst_busy", BUSY, 0);
        chk("rst_dvalid", DVALID, 0);
        chk("rst_dout", DOUT, 0);
        chk("rst_frame_done", FRAME_DONE, 0);
        chk("rst_ovr", OVR_CNT, 0);
        RST = 1'b0;
        tick();

        // DREADY alone does nothing while idle
        DREADY = 1'b1;
        tick();
        chk("idle_dvalid", DVALID, 0);
        chk("idle_busy", BUSY, 0);

        // Basic frame
        set_din_basic();
        set_exp_basic();
        start_frame();
        stream(0, 0, 0);
        tick();
        chk("basic_done_low", FRAME_DONE, 0);

        // Backpressure
        start_frame();
        stream(1, 0, 0);
        tick();
        chk("bp_done_low", FRAME_DONE, 0);

        // Overrun: three dropped LOADs, data of the first frame kept
        set_din_basic();
        start_frame();
        stream(0, 1, 0);
        chk("ovr_cnt_3", OVR_CNT, 3);
        tick();

        // Back-to-back: LOAD on the final handshake
        set_din_basic();
        start_frame();
        stream(0, 0, 1);
        chk("b2b_ovr_unchanged", OVR_CNT, 3);
        set_exp_ff();
        stream(0, 0, 0);
        tick();
        chk("b2b_done_low", FRAME_DONE, 0);

        // Saturation: LOAD held for 300 cycles while stalled in sync
        set_din_basic();
        set_exp_basic();
        start_frame();
        DREADY = 1'b0;
        LOAD   = 1'b1;
        repeat (300) tick();
        LOAD = 1'b0;
        chk("ovr_sat", OVR_CNT, 255);
        chk("stall_sync_held", DOUT, 8'hAA);
        chk("stall_dvalid_held", DVALID, 1);
        stream(0, 0, 0);
        tick();

        // Asynchronous reset mid-frame after 11 handshakes
        start_frame();
        DREADY = 1'b1;
        repeat (11) tick();
        chk("pre_rst_byte10", DOUT, 8'h13);
        #2 RST = 1'b1;
        #1;
        chk("arst_dvalid", DVALID, 0);
        chk("arst_busy", BUSY, 0);
        chk("arst_frame_done", FRAME_DONE, 0);
        chk("arst_ovr", OVR_CNT, 0);
        chk("arst_dout", DOUT, 0);
        tick();
        RST = 1'b0;
        tick();
        chk("post_rst_done", FRAME_DONE, 0);
        chk("post_rst_dvalid", DVALID, 0);
        set_din_basic();
        start_frame();
        stream(0, 0, 0);
        tick();
        chk("final_ovr", OVR_CNT, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
